latch_exerciser: RTL and testbench
==================================

// Module: latch_exerciser
// PURPOSE
//  Synchronous initiator that drives the D/gate inputs of an external gated D latch.
//  Samples the latch's Q/Qn, compares them against a reference model, and reports pass/fail.
//  Sits between board clock/switches and the latch under test; results go to LEDR.
//  Runs a fixed 8-vector sequence per start request.
// PARAMETERS
//  SETTLE_CYCLES  4  cycles from gate change to sampling; range 3..15 (covers the 2-flop sync)
// PORTS
//  clk            in   1  sole clock; all state updates on rising edge
//  reset          in   1  synchronous, active-high; evaluated on clk rising edge
//  start          in   1  run request; level sampled only in IDLE/DONE
//  lat_q          in   1  latch Q (Qa), asynchronous to clk
//  lat_qn         in   1  latch Qn (Qb), asynchronous to clk
//  lat_d          out  1  registered D drive to latch
//  lat_g          out  1  registered gate (enable) drive to latch
//  busy           out  1  high from first SETUP through last CLOSE
//  done           out  1  high in DONE; holds until next start or reset
//  pass           out  1  done && fail_count==0
//  fail_count     out  4  number of failing vectors, 0..8
//  first_fail_idx out  3  index of first failing vector; valid when fail_count!=0
// BEHAVIOUR
//  Reset values: lat_d=0, lat_g=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0;
//    state=IDLE, idx=0, exp_q=0.
//  Reset mid-run: abort at the next edge; lat_g drops to 0 at that edge; no partial results kept.
//  Vector table (idx: D,G): 0:1,1  1:0,0  2:0,1  3:1,0  4:1,1  5:1,1  6:0,1  7:1,0
//  Model exp_q: at GATE, if vector G=1 then exp_q<=vector D, else exp_q holds.
//    Resulting expected Q sequence: 1,1,0,0,1,1,0,0.
//  lat_q/lat_qn each pass through a 2-flop synchronizer before use.
//  FSM:
//    IDLE   : start=1 -> clear fail_count/first_fail_idx, idx=0 -> SETUP.
//    SETUP  : lat_d<=vec D, lat_g<=0 (D is set up while the gate is closed) -> GATE.
//    GATE   : lat_g<=vec G; update exp_q; settle counter<=0 -> SETTLE.
//    SETTLE : wait SETTLE_CYCLES cycles -> CHECK.
//    CHECK  : vector passes iff q_s==exp_q && qn_s==~exp_q (both tested).
//             On mismatch: fail_count++; if fail_count was 0, first_fail_idx<=idx. -> CLOSE.
//    CLOSE  : lat_g<=0.
//             idx==7 -> DONE; else idx++ -> SETUP.
//    DONE   : done=1, busy=0; start=1 -> restart as from IDLE (clear results, done<=0).
//  Ordering rule: lat_d never changes while lat_g=1 (hold-time safety for the latch).
//  Timing: per-vector latency = SETTLE_CYCLES+4 cycles.
//    done rises 8*(SETTLE_CYCLES+4)+1 cycles after start is sampled in IDLE.
//  start is ignored while busy; start held high in DONE re-runs continuously.
//  fail_count max is 8, so it cannot wrap; idx wraps only via the CLOSE->DONE exit.
//  Undefined latch state before vector 0 is harmless: vector 0 has G=1.
// STRUCTURE
//  Shared package latch_test_pkg: state encoding localparams, VEC_COUNT=8, vector table constant.
//  Sub-module sync_2ff (1-bit, clk, reset->0): instantiated once each for lat_q and lat_qn.
//  Remainder in one always block (FSM, counters, drive regs) plus one combinational pass assign.
// TESTING
//  1 reset held 3 cycles -> all outputs 0, lat_g=0; start ignored while reset=1.
//  2 bench behavioural good latch, SETTLE=4, start pulse
//      -> done at cycle 8*8+1=65; pass=1; fail_count=0; lat_d stable whenever lat_g=1.
//  3 lat_q stuck at 0, lat_qn=~lat_q
//      -> fails idx 0,1,4,5; fail_count=4, first_fail_idx=0, pass=0.
//  4 transparent-only fault (Q=D, gate ignored)
//      -> fails idx 1,3,7; fail_count=3, first_fail_idx=1.
//  5 lat_qn tied to lat_q (non-complementary) -> all vectors fail; fail_count=8, first_fail_idx=0.
//  6 reset asserted during idx 3 SETTLE
//      -> next edge: busy=0, lat_g=0, fail_count=0.
//      Then start during busy is ignored; a fresh start completes as in test 2.

Source files
------------

// File: rtl/latch_test_pkg.sv
// latch_test_pkg
// Shared definitions for the gated D latch exerciser: FSM state encoding,
// the vector count and the fixed D/G stimulus table, plus small lookup
// helpers so the FSM can read a vector's D or G bit by index.
package latch_test_pkg;

   localparam int VEC_COUNT = 8;

   // Explicit encodings keep the state values stable across tools.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_GATE   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_CHECK  = 3'd4,
      ST_CLOSE  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Bit i of each word belongs to vector i.
   // D per index 0..7: 1,0,0,1,1,1,0,1
   // G per index 0..7: 1,0,1,0,1,1,1,0
   localparam logic [VEC_COUNT-1:0] VEC_D = 8'b1011_1001;
   localparam logic [VEC_COUNT-1:0] VEC_G = 8'b0111_0101;

   function automatic logic vecD(input logic [2:0] idx);
      return VEC_D[idx];
   endfunction

   function automatic logic vecG(input logic [2:0] idx);
      return VEC_G[idx];
   endfunction

endpackage

// File: rtl/latch_exerciser_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk    - sampling clock
//   reset  - synchronous active-high reset, clears both stages to 0
//   i_d    - asynchronous input bit
//   o_q    - synchronized output, two clk edges behind i_d
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;

   // First stage may go metastable; second stage gives it a full cycle to resolve.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         o_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         o_q    <= r_meta;
      end
   end

endmodule

// File: rtl/latch_exerciser.sv
// latch_exerciser
// Drives D and gate of an external gated D latch through a fixed 8-vector
// sequence, samples the latch's Q/Qn after a settle delay, compares them
// against a reference latch model and reports the result.
// Ports:
//   clk            - sole clock, rising edge
//   reset          - synchronous active-high reset
//   start          - run request, only looked at in IDLE or DONE
//   lat_q, lat_qn  - latch outputs, asynchronous to clk
//   lat_d, lat_g   - registered D and gate drives to the latch
//   busy           - high from the first SETUP through the last CLOSE
//   done           - high in DONE until the next start or reset
//   pass           - done with no failing vectors
//   fail_count     - number of failing vectors (0..8)
//   first_fail_idx - index of the first failing vector
// SETTLE_CYCLES (3..15) is the wait between a gate change and the check;
// the lower bound covers the two-flop synchronizer latency.
module latch_exerciser
   import latch_test_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       lat_q,
   input  logic       lat_qn,
   output logic       lat_d,
   output logic       lat_g,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_count,
   output logic [2:0] first_fail_idx
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] IDX_LAST    = 3'(VEC_COUNT - 1);

   state_t     r_state;
   logic [2:0] r_idx;
   logic [3:0] r_settleCnt;
   logic       r_expQ;
   logic       w_qSync;
   logic       w_qnSync;
   logic       w_vecOk;

   sync_2ff u_syncQ (
      .clk   (clk),
      .reset (reset),
      .i_d   (lat_q),
      .o_q   (w_qSync)
   );

   sync_2ff u_syncQn (
      .clk   (clk),
      .reset (reset),
      .i_d   (lat_qn),
      .o_q   (w_qnSync)
   );

   // Both outputs must match the model; a latch whose Qn is not the
   // complement of Q is a failure even if Q itself is right.
   assign w_vecOk = (w_qSync == r_expQ) && (w_qnSync == ~r_expQ);

   assign pass = done && (fail_count == 4'd0);

   // Sequencer: D is only ever changed in SETUP, which is always entered
   // with the gate closed, so D is stable for the whole time the gate is
   // open. The reference model exp_q is updated at the same edge the gate
   // drive is applied, mirroring what an ideal latch would do.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_idx          <= 3'd0;
         r_settleCnt    <= 4'd0;
         r_expQ         <= 1'b0;
         lat_d          <= 1'b0;
         lat_g          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         fail_count     <= 4'd0;
         first_fail_idx <= 3'd0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  fail_count     <= 4'd0;
                  first_fail_idx <= 3'd0;
                  r_idx          <= 3'd0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  r_state        <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               lat_d   <= vecD(r_idx);
               lat_g   <= 1'b0;
               r_state <= ST_GATE;
            end
            ST_GATE: begin
               lat_g <= vecG(r_idx);
               if (vecG(r_idx)) begin
                  r_expQ <= vecD(r_idx);
               end
               r_settleCnt <= 4'd0;
               r_state     <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_settleCnt == SETTLE_LAST) begin
                  r_state <= ST_CHECK;
               end else begin
                  r_settleCnt <= r_settleCnt + 4'd1;
               end
            end
            ST_CHECK: begin
               if (!w_vecOk) begin
                  fail_count <= fail_count + 4'd1;
                  if (fail_count == 4'd0) begin
                     first_fail_idx <= r_idx;
                  end
               end
               r_state <= ST_CLOSE;
            end
            ST_CLOSE: begin
               lat_g <= 1'b0;
               if (r_idx == IDX_LAST) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx   <= r_idx + 3'd1;
                  r_state <= ST_SETUP;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latch_exerciser.sv
// tb_latch_exerciser
// Directed bench for latch_exerciser. A behavioural gated D latch sits on
// lat_d/lat_g; a fault mode can replace its outputs with stuck, transparent
// or non-complementary behaviour. Expected results are hand-computed from
// the vector table (expected Q sequence 1,1,0,0,1,1,0,0).
module tb_latch_exerciser;

   logic       clk;
   logic       reset;
   logic       start;
   logic       lat_q;
   logic       lat_qn;
   logic       lat_d;
   logic       lat_g;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_count;
   logic [2:0] first_fail_idx;

   int   latchMode;
   logic goodQ;
   int   totalChecks;
   int   badChecks;
   int   holdViolations;
   logic prevD;
   logic prevG;
   logic busyAfterStart;

   latch_exerciser #(.SETTLE_CYCLES(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .lat_q          (lat_q),
      .lat_qn         (lat_qn),
      .lat_d          (lat_d),
      .lat_g          (lat_g),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail_count     (fail_count),
      .first_fail_idx (first_fail_idx)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ideal gated D latch: transparent while gate is high, holds otherwise.
   always @(lat_d or lat_g) begin
      if (lat_g) goodQ = lat_d;
   end

   // Fault injection: 0 good, 1 Q stuck at 0, 2 transparent-only, 3 Qn tied to Q.
   always_comb begin
      lat_q  = goodQ;
      lat_qn = ~goodQ;
      case (latchMode)
         1: begin
            lat_q  = 1'b0;
            lat_qn = 1'b1;
         end
         2: begin
            lat_q  = lat_d;
            lat_qn = ~lat_d;
         end
         3: begin
            lat_qn = goodQ;
         end
         default: ;
      endcase
   end

   // Watches for D moving while the gate is (or just was) open.
   initial begin
      holdViolations = 0;
      prevD = 1'b0;
      prevG = 1'b0;
      forever begin
         @(negedge clk);
         if ((prevG || lat_g) && (lat_d !== prevD)) holdViolations++;
         prevD = lat_d;
         prevG = lat_g;
      end
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalChecks++;
      if (observed != expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
      end
   endtask

   // Pulses start for one cycle and counts rising edges, the sampling edge
   // being edge 1, until done is seen. pokeEdge (if nonzero) re-asserts
   // start for one cycle mid-run, which must be ignored.
   task automatic applyStimulus(input int faultMode, input int pokeEdge, output int doneEdge);
      int edgeCount;
      latchMode = faultMode;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      edgeCount = 1;
      @(negedge clk);
      start = 1'b0;
      busyAfterStart = busy;
      doneEdge = -1;
      while (edgeCount < 200 && doneEdge < 0) begin
         if (edgeCount == pokeEdge) start = 1'b1;
         @(posedge clk);
         edgeCount++;
         @(negedge clk);
         start = 1'b0;
         if (done) doneEdge = edgeCount;
      end
   endtask

   initial begin
      int doneEdge;
      int violBefore;
      totalChecks = 0;
      badChecks   = 0;
      latchMode   = 0;
      reset       = 1'b1;
      start       = 1'b1;

      // Reset held 3 cycles with start high: nothing may begin.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_lat_d", int'(lat_d), 0);
      checkOutput("rst_lat_g", int'(lat_g), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_pass", int'(pass), 0);
      checkOutput("rst_fail_count", int'(fail_count), 0);
      checkOutput("rst_first_fail", int'(first_fail_idx), 0);
      start = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Good latch: done at edge 65, clean pass, D never moves with gate open.
      violBefore = holdViolations;
      applyStimulus(0, 0, doneEdge);
      checkOutput("good_busy_after_start", int'(busyAfterStart), 1);
      checkOutput("good_done_edge", doneEdge, 65);
      checkOutput("good_pass", int'(pass), 1);
      checkOutput("good_fail_count", int'(fail_count), 0);
      checkOutput("good_busy_at_done", int'(busy), 0);
      checkOutput("good_hold_violations", holdViolations - violBefore, 0);
      repeat (3) @(negedge clk);
      checkOutput("good_done_holds", int'(done), 1);

      // Q stuck at 0: expected-1 vectors 0,1,4,5 fail.
      applyStimulus(1, 0, doneEdge);
      checkOutput("stuck_done_edge", doneEdge, 65);
      checkOutput("stuck_fail_count", int'(fail_count), 4);
      checkOutput("stuck_first_fail", int'(first_fail_idx), 0);
      checkOutput("stuck_pass", int'(pass), 0);

      // Transparent-only: Q follows D, vectors 1,3,7 fail.
      applyStimulus(2, 0, doneEdge);
      checkOutput("transp_done_edge", doneEdge, 65);
      checkOutput("transp_fail_count", int'(fail_count), 3);
      checkOutput("transp_first_fail", int'(first_fail_idx), 1);
      checkOutput("transp_pass", int'(pass), 0);

      // Qn tied to Q: every vector fails.
      applyStimulus(3, 0, doneEdge);
      checkOutput("qntie_fail_count", int'(fail_count), 8);
      checkOutput("qntie_first_fail", int'(first_fail_idx), 0);
      checkOutput("qntie_pass", int'(pass), 0);

      // Reset during vector 3 SETTLE (state is SETTLE after edge 28).
      // Vectors 0 and 1 have already failed with Q stuck at 0.
      latchMode = 1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (27) @(posedge clk);
      @(negedge clk);
      checkOutput("abort_busy_before", int'(busy), 1);
      checkOutput("abort_fail_before", int'(fail_count), 2);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_lat_g", int'(lat_g), 0);
      checkOutput("abort_fail_count", int'(fail_count), 0);
      reset = 1'b0;
      @(negedge clk);

      // Fresh run with a stray start pulse mid-run, which must not disturb it.
      applyStimulus(0, 20, doneEdge);
      checkOutput("rerun_done_edge", doneEdge, 65);
      checkOutput("rerun_pass", int'(pass), 1);
      checkOutput("rerun_fail_count", int'(fail_count), 0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
